// File: rtl/plane_rw_buf_if.sv
// rtl/plane_rw_buf_if.sv - Write/read handshake bundle for plane_rw_buf
interface plane_rw_buf_if #(
    parameter int DW    = 11,
    parameter int NCH   = 3,
    parameter int NR    = 2,
    parameter int NC    = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
);
    logic                                   wr_valid;
    logic                                   wr_ready;
    logic                                   wr_mode;
    logic [CW-1:0]                          wr_ch;
    logic [AW-1:0]                          wr_addr;
    logic [NCH-1:0][NR-1:0][NC-1:0][DW-1:0] b;
    logic                                   rd_req_valid;
    logic                                   rd_req_ready;
    logic [AW-1:0]                          rd_addr;
    logic                                   rd_rsp_valid;
    logic                                   rd_rsp_ready;
    logic [NR-1:0][NC-1:0][DW-1:0]          c;
    logic [AW-1:0]                          rd_rsp_addr;
    logic                                   busy;

    modport master (
        output wr_valid, wr_mode, wr_ch, wr_addr, b, rd_req_valid, rd_addr, rd_rsp_ready,
        input  wr_ready, rd_req_ready, rd_rsp_valid, c, rd_rsp_addr, busy
    );

    modport slave (
        input  wr_valid, wr_mode, wr_ch, wr_addr, b, rd_req_valid, rd_addr, rd_rsp_ready,
        output wr_ready, rd_req_ready, rd_rsp_valid, c, rd_rsp_addr, busy
    );
endinterface

// File: rtl/plane_rw_buf.sv
// rtl/plane_rw_buf.sv - DEPTH-entry plane buffer with overwrite/accumulate writes and a registered read response
module plane_rw_buf #(
    parameter int DW    = 11,
    parameter int NCH   = 3,
    parameter int NR    = 2,
    parameter int NC    = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic         clk,
    input  logic         rst,
    plane_rw_buf_if.slave bus
);
    typedef logic [NR-1:0][NC-1:0][DW-1:0] plane_t;
    typedef enum logic {S_IDLE, S_ACC} state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [CW:0] LP_NCH   = (CW+1)'(NCH);

    state_t        r_state;
    state_t        w_next_state;
    plane_t        r_mem [DEPTH];
    plane_t        r_op;
    logic [AW-1:0] r_acc_addr;
    logic          r_rsp_valid;
    plane_t        r_c;
    logic [AW-1:0] r_rsp_addr;

    logic          w_wr_ok;
    logic          w_wr_ready;
    logic          w_ow;
    logic          w_acc_start;
    plane_t        w_sel;
    logic          w_rd_ready;
    logic          w_rd_fire;
    logic          w_rd_in_range;

    // Bad channel or address: the write handshakes but has no effect
    always_comb begin
        w_wr_ok = ({1'b0, bus.wr_ch} < LP_NCH) && ({1'b0, bus.wr_addr} < LP_DEPTH);
        w_sel   = '0;
        if (w_wr_ok) begin
            w_sel = bus.b[bus.wr_ch];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr_ready   = 1'b0;
        w_ow         = 1'b0;
        w_acc_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_ready = 1'b1;
                if (bus.wr_valid && w_wr_ok) begin
                    if (bus.wr_mode) begin
                        w_acc_start  = 1'b1;
                        w_next_state = S_ACC;
                    end else begin
                        w_ow = 1'b1;
                    end
                end
            end
            S_ACC: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= '0;
            r_acc_addr <= '0;
        end else if (w_acc_start) begin
            r_op       <= w_sel;
            r_acc_addr <= bus.wr_addr;
        end
    end

    // Element-wise add so carries never cross word boundaries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_ow) begin
            r_mem[bus.wr_addr] <= w_sel;
        end else if (r_state == S_ACC) begin
            for (int r = 0; r < NR; r++) begin
                for (int k = 0; k < NC; k++) begin
                    r_mem[r_acc_addr][r][k] <= r_mem[r_acc_addr][r][k] + r_op[r][k];
                end
            end
        end
    end

    assign w_rd_ready    = !r_rsp_valid || bus.rd_rsp_ready;
    assign w_rd_fire     = bus.rd_req_valid && w_rd_ready;
    assign w_rd_in_range = ({1'b0, bus.rd_addr} < LP_DEPTH);

    // Sampling r_mem here sees the pre-edge contents, giving read-before-write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_c         <= '0;
            r_rsp_addr  <= '0;
        end else if (w_rd_fire) begin
            r_rsp_valid <= 1'b1;
            r_c         <= w_rd_in_range ? r_mem[bus.rd_addr] : '0;
            r_rsp_addr  <= bus.rd_addr;
        end else if (bus.rd_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.wr_ready     = w_wr_ready;
    assign bus.busy         = (r_state == S_ACC);
    assign bus.rd_req_ready = w_rd_ready;
    assign bus.rd_rsp_valid = r_rsp_valid;
    assign bus.c            = r_c;
    assign bus.rd_rsp_addr  = r_rsp_addr;
endmodule

// File: tb/tb_plane_rw_buf.sv
// tb/tb_plane_rw_buf.sv - Scoreboard bench for plane_rw_buf
module tb_plane_rw_buf;
    localparam int DW    = 11;
    localparam int NCH   = 3;
    localparam int NR    = 2;
    localparam int NC    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 2;

    typedef logic [NR-1:0][NC-1:0][DW-1:0] plane_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    plane_t        model [DEPTH];
    plane_t        exp_q [$];
    logic [AW-1:0] exp_addr_q [$];
    plane_t        mon_e;
    logic [AW-1:0] mon_a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    plane_rw_buf_if #(.DW(DW), .NCH(NCH), .NR(NR), .NC(NC), .DEPTH(DEPTH)) bus ();

    plane_rw_buf #(.DW(DW), .NCH(NCH), .NR(NR), .NC(NC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic plane_t fill(input logic [DW-1:0] v);
        plane_t p;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NC; k++)
                p[r][k] = v;
        return p;
    endfunction

    function automatic plane_t ramp();
        plane_t p;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NC; k++)
                p[r][k] = DW'(r * 4 + k + 1);
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.rd_rsp_valid && bus.rd_rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_extra: got response addr %0d, expected none", bus.rd_rsp_addr);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = exp_addr_q.pop_front();
                if (bus.c !== mon_e || bus.rd_rsp_addr !== mon_a) begin
                    errors++;
                    $display("FAIL rsp_data: got addr %0d c %h, expected addr %0d c %h",
                             bus.rd_rsp_addr, bus.c, mon_a, mon_e);
                end
            end
        end
    end

    task automatic read_issue(input logic [AW-1:0] addr);
        int n = 0;
        bus.rd_req_valid = 1'b1;
        bus.rd_addr      = addr;
        @(negedge clk);
        while (!bus.rd_req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!bus.rd_req_ready) begin
            errors++;
            $display("FAIL rd_accept_timeout: rd_req_ready %0b, expected 1", bus.rd_req_ready);
        end else begin
            @(posedge clk);
            exp_q.push_back(model[addr]);
            exp_addr_q.push_back(addr);
        end
        #1;
        bus.rd_req_valid = 1'b0;
    endtask

    task automatic write_issue(input logic mode, input logic [CW-1:0] ch,
                               input logic [AW-1:0] addr, input plane_t p);
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_mode  = mode;
        bus.wr_ch    = ch;
        bus.wr_addr  = addr;
        for (int j = 0; j < NCH; j++) bus.b[j] = fill(DW'(16 + j));
        if (int'(ch) < NCH) bus.b[ch] = p;
        @(negedge clk);
        while (!bus.wr_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!bus.wr_ready) begin
            errors++;
            $display("FAIL wr_accept_timeout: wr_ready %0b, expected 1", bus.wr_ready);
        end else begin
            @(posedge clk);
            if (int'(ch) < NCH) begin
                if (!mode) model[addr] = p;
                else
                    for (int r = 0; r < NR; r++)
                        for (int k = 0; k < NC; k++)
                            model[addr][r][k] = model[addr][r][k] + p[r][k];
            end
        end
        #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(posedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.wr_valid = 1'b0; bus.wr_mode = 1'b0; bus.wr_ch = '0; bus.wr_addr = '0; bus.b = '0;
        bus.rd_req_valid = 1'b0; bus.rd_addr = '0; bus.rd_rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #12;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %0b, expected 1", bus.wr_ready); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, expected 0", bus.busy); end
        checks++;
        if (bus.rd_req_ready !== 1'b1) begin errors++; $display("FAIL rst_rd_req_ready: got %0b, expected 1", bus.rd_req_ready); end
        checks++;
        if (bus.rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b, expected 0", bus.rd_rsp_valid); end
        checks++;
        if (bus.c !== '0 || bus.rd_rsp_addr !== '0) begin
            errors++; $display("FAIL rst_c: got c %h addr %0d, expected 0 and 0", bus.c, bus.rd_rsp_addr);
        end
        @(posedge clk); #1;
        for (int a = 0; a < DEPTH; a++) read_issue(AW'(a));
        drain();
    endtask

    task automatic test_overwrite();
        write_issue(1'b0, 2'd2, 2'd1, ramp());
        read_issue(2'd1);
        read_issue(2'd0);
        read_issue(2'd2);
        read_issue(2'd3);
        drain();
    endtask

    task automatic test_bad_channel();
        write_issue(1'b0, 2'd3, 2'd0, fill(11'd9));
        write_issue(1'b1, 2'd3, 2'd0, fill(11'd9));
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL badch_busy: got %0b, expected 0", bus.busy); end
        read_issue(2'd0);
        drain();
    endtask

    task automatic test_accumulate_wrap();
        write_issue(1'b0, 2'd0, 2'd3, fill(11'h7FF));
        write_issue(1'b1, 2'd0, 2'd3, fill(11'd2));
        checks++;
        if (bus.wr_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL acc_in_acc: got wr_ready %0b busy %0b, expected 0 1", bus.wr_ready, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL acc_after: got wr_ready %0b busy %0b, expected 1 0", bus.wr_ready, bus.busy);
        end
        read_issue(2'd3);
        drain();
    endtask

    task automatic test_back_to_back();
        int t0;
        write_issue(1'b0, 2'd1, 2'd1, fill(11'd100));
        t0 = cyc;
        write_issue(1'b0, 2'd2, 2'd2, fill(11'd200));
        checks++;
        if (cyc - t0 !== 1) begin errors++; $display("FAIL b2b_write: got %0d cycles, expected 1", cyc - t0); end
        read_issue(2'd1);
        t0 = cyc;
        read_issue(2'd2);
        checks++;
        if (cyc - t0 !== 1) begin errors++; $display("FAIL b2b_read: got %0d cycles, expected 1", cyc - t0); end
        drain();
    endtask

    task automatic test_backpressure();
        plane_t        first_e;
        bus.rd_rsp_ready = 1'b0;
        fork
            begin
                read_issue(2'd1);
                read_issue(2'd2);
                read_issue(2'd3);
            end
            begin
                @(posedge clk); #1;
                first_e = (exp_q.size() != 0) ? exp_q[0] : '1;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (bus.rd_rsp_valid !== 1'b1 || bus.rd_req_ready !== 1'b0) begin
                        errors++; $display("FAIL bp_hold: got rsp_valid %0b rd_req_ready %0b, expected 1 0",
                                           bus.rd_rsp_valid, bus.rd_req_ready);
                    end
                    checks++;
                    if (bus.c !== first_e || bus.rd_rsp_addr !== 2'd1) begin
                        errors++; $display("FAIL bp_stable: got addr %0d c %h, expected addr 1 c %h",
                                           bus.rd_rsp_addr, bus.c, first_e);
                    end
                end
                @(posedge clk); #1;
                bus.rd_rsp_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (bus.rd_rsp_valid !== 1'b1) begin
                        errors++; $display("FAIL bp_stream: got rsp_valid %0b, expected 1", bus.rd_rsp_valid);
                    end
                end
            end
        join
        bus.rd_rsp_ready = 1'b1;
        drain();
    endtask

    task automatic test_same_cycle_hazard();
        bus.wr_valid = 1'b1; bus.wr_mode = 1'b0; bus.wr_ch = 2'd0; bus.wr_addr = 2'd0;
        bus.b = '0; bus.b[0] = fill(11'd5);
        bus.rd_req_valid = 1'b1; bus.rd_addr = 2'd0;
        @(negedge clk);
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.rd_req_ready !== 1'b1) begin
            errors++; $display("FAIL haz_ready: got wr_ready %0b rd_req_ready %0b, expected 1 1",
                               bus.wr_ready, bus.rd_req_ready);
        end
        @(posedge clk);
        exp_q.push_back(model[0]);
        exp_addr_q.push_back(2'd0);
        model[0] = fill(11'd5);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_req_valid = 1'b0;
        read_issue(2'd0);
        drain();
    endtask

    task automatic test_reset_mid_acc();
        write_issue(1'b0, 2'd1, 2'd2, fill(11'd1));
        write_issue(1'b1, 2'd1, 2'd2, fill(11'd7));
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL midacc_busy: got %0b, expected 1", bus.busy); end
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1 || bus.rd_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midacc_state: got busy %0b wr_ready %0b rsp_valid %0b, expected 0 1 0",
                               bus.busy, bus.wr_ready, bus.rd_rsp_valid);
        end
        @(posedge clk); #1;
        read_issue(2'd2);
        read_issue(2'd1);
        drain();
    endtask

    initial begin
        test_reset();
        test_overwrite();
        test_bad_channel();
        test_accumulate_wrap();
        test_back_to_back();
        test_backpressure();
        test_same_cycle_hazard();
        test_reset_mid_acc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
